// File: rtl/wasm_value_stack.sv
// wasm_value_stack: operand value stack feeding the 32-bit ALU with top-3 entries
// Ports: clk, rst_n (async active-low); op_valid/op_ready request handshake;
//   pop_cnt (0..3) entries popped, then push_data pushed when push_en; flush empties and clears trap;
//   opnd_a/b/c = top, top-1, top-2 (0 when absent); depth = entry count;
//   trap/trap_code = sticky fault (01 underflow, 10 overflow).
// Optional: define WSTACK_HWM_EN to add hwm, the max depth since reset/flush.
module wasm_value_stack #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        pop_cnt,
  input  logic              push_en,
  input  logic [31:0]       push_data,
  input  logic              flush,
  output logic [31:0]       opnd_a,
  output logic [31:0]       opnd_b,
  output logic [31:0]       opnd_c,
  output logic [ADDR_W:0]   depth,
  output logic              trap,
  output logic [1:0]        trap_code
`ifdef WSTACK_HWM_EN
  ,
  output logic [ADDR_W:0]   hwm
`endif
);
  typedef enum logic {RUN, TRAP} state_t;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [ADDR_W:0] p, u, base, nd, depth_nx;
  logic [ADDR_W-1:0] ia, ib, ic;
  logic [1:0] code_nx;
  logic acc, udf, ovf, wr;
  always_comb begin
    p        = {{(ADDR_W-1){1'b0}}, pop_cnt};
    u        = {{ADDR_W{1'b0}}, push_en};
    base     = depth - p;
    nd       = base + u;
    op_ready = (state == RUN) && !flush;
    acc      = op_valid && op_ready;
    udf      = p > depth;
    ovf      = !udf && (nd > FULL);
    wr       = acc && !udf && !ovf;
    state_nx = flush ? RUN : (acc && (udf || ovf)) ? TRAP : state;
    code_nx  = flush ? 2'b00 : (acc && udf) ? 2'b01 : (acc && ovf) ? 2'b10 : trap_code;
    depth_nx = flush ? '0 : wr ? nd : depth;
    trap     = state == TRAP;
    ia       = depth[ADDR_W-1:0] - ADDR_W'(1);
    ib       = depth[ADDR_W-1:0] - ADDR_W'(2);
    ic       = depth[ADDR_W-1:0] - ADDR_W'(3);
    opnd_a   = (depth > (ADDR_W+1)'(0)) ? mem[ia] : '0;
    opnd_b   = (depth > (ADDR_W+1)'(1)) ? mem[ib] : '0;
    opnd_c   = (depth > (ADDR_W+1)'(2)) ? mem[ic] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= RUN;
      depth     <= '0;
      trap_code <= 2'b00;
    end else begin
      state     <= state_nx;
      depth     <= depth_nx;
      trap_code <= code_nx;
    end
  // Popped slots keep their data; a push after popping simply overwrites at the new base.
  always_ff @(posedge clk)
    if (wr && push_en) mem[base[ADDR_W-1:0]] <= push_data;
`ifdef WSTACK_HWM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hwm <= '0;
    else hwm <= flush ? '0 : (depth_nx > hwm) ? depth_nx : hwm;
`endif
endmodule
